// File: rtl/weight_load_ctrl.sv
// weight_load_ctrl: decodes BIU weight beats into per-group lanes and per-PE tap enables,
// and runs the ping-pong bank fill/full/release control; WLU_ERR_CNT_EN builds the illegal-tap counter.
module weight_load_ctrl #(
  parameter int ARRAY_NUM = 32,
  parameter int GROUP = 4,
  parameter int DATA_W = 32,
  parameter int TAPS = 9,
  parameter int GRP_W = $clog2(ARRAY_NUM / GROUP)
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [31:0]                          weight_waddr,
  input  logic [DATA_W-1:0]                    weight_wdata,
  input  logic                                 weight_valid,
  output logic                                 weight_ready,
  input  logic                                 bank_release,
  output logic [(ARRAY_NUM/GROUP)*DATA_W-1:0]  weight_load,
  output logic [ARRAY_NUM*(TAPS+1)-1:0]        weight_load_en,
  output logic [1:0]                           weight_load_sel,
  output logic [1:0]                           bank_full,
  output logic                                 rd_bank,
  output logic [15:0]                          err_cnt
);
  localparam int NG = ARRAY_NUM / GROUP;
  localparam int EW = TAPS + 1;
  typedef enum logic [1:0] {EMPTY = 2'd0, FILLING = 2'd1, FULL = 2'd2} bank_t;
  bank_t bank_q [2];
  bank_t bank_d [2];
  logic wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
  logic [NG*DATA_W-1:0] load_q, load_d;
  logic [ARRAY_NUM*EW-1:0] en_q, en_d;
  logic [1:0] sel_q, sel_d;
  logic mode, acc, last, bad_tap;
  logic [3:0] tap;
  logic [GRP_W-1:0] grp;
  logic [TAPS-1:0] oh;
  logic [EW-1:0] base;
  logic unused_ok;
  assign mode = weight_waddr[31];
  assign tap = weight_waddr[9:6];
  assign grp = weight_waddr[GRP_W-1:0];
  assign unused_ok = ^{weight_waddr[30:10], weight_waddr[5:4]};
  assign weight_ready = bank_q[wr_bank_q] != FULL;
  assign acc = weight_valid && weight_ready;
  assign bad_tap = tap >= 4'(TAPS);
  assign last = weight_waddr[3:0] == 4'hF && (mode || tap == 4'(TAPS - 1));
  assign oh = bad_tap ? '0 : TAPS'(1) << tap;
  assign base = mode ? {1'b1, {TAPS{1'b0}}} : {1'b0, oh};
  // Release is resolved before the beat so one bank can empty while the other fills up.
  always_comb begin
    bank_d = bank_q;
    rd_bank_d = rd_bank_q;
    wr_bank_d = wr_bank_q;
    if (bank_release && bank_q[rd_bank_q] == FULL) begin
      bank_d[rd_bank_q] = EMPTY;
      rd_bank_d = !rd_bank_q;
    end
    if (acc) begin
      bank_d[wr_bank_q] = last ? FULL : FILLING;
      wr_bank_d = last ? !wr_bank_q : wr_bank_q;
    end
    sel_d = acc ? {wr_bank_q, weight_waddr[3]} : sel_q;
    load_d = acc ? '0 : load_q;
    en_d = '0;
    for (int g = 0; g < NG; g++)
      if (acc && grp == GRP_W'(g)) load_d[g*DATA_W +: DATA_W] = weight_wdata;
    for (int p = 0; p < ARRAY_NUM; p++)
      if (acc && grp == GRP_W'(p / GROUP)) en_d[p*EW +: EW] = base;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bank_q <= '{EMPTY, EMPTY};
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      load_q <= '0;
      en_q <= '0;
      sel_q <= '0;
    end else begin
      bank_q <= bank_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      load_q <= load_d;
      en_q <= en_d;
      sel_q <= sel_d;
    end
  assign weight_load = load_q;
  assign weight_load_en = en_q;
  assign weight_load_sel = sel_q;
  assign bank_full = {bank_q[1] == FULL, bank_q[0] == FULL};
  assign rd_bank = rd_bank_q;
`ifdef WLU_ERR_CNT_EN
  logic [15:0] err_q, err_d;
  assign err_d = (acc && !mode && bad_tap && err_q != 16'hFFFF) ? err_q + 16'd1 : err_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) err_q <= '0;
    else err_q <= err_d;
  assign err_cnt = err_q;
`else
  assign err_cnt = '0;
`endif
endmodule

// File: tb/tb_weight_load_ctrl.sv
// tb_weight_load_ctrl: vector table, corner-case sequences and random traffic against a bank/beat model.
module tb_weight_load_ctrl;
`ifdef WLU_ERR_CNT_EN
  localparam bit ERR_ON = 1'b1;
`else
  localparam bit ERR_ON = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n;
  logic [31:0] weight_waddr = '0;
  logic [31:0] weight_wdata = '0;
  logic weight_valid = 1'b0;
  logic weight_ready;
  logic bank_release = 1'b0;
  logic [255:0] weight_load;
  logic [319:0] weight_load_en;
  logic [1:0] weight_load_sel;
  logic [1:0] bank_full;
  logic rd_bank;
  logic [15:0] err_cnt;
  int checks = 0;
  int failures = 0;

  weight_load_ctrl dut (
    .clk(clk), .rst_n(rst_n), .weight_waddr(weight_waddr), .weight_wdata(weight_wdata),
    .weight_valid(weight_valid), .weight_ready(weight_ready), .bank_release(bank_release),
    .weight_load(weight_load), .weight_load_en(weight_load_en), .weight_load_sel(weight_load_sel),
    .bank_full(bank_full), .rd_bank(rd_bank), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int m_state [2];
  int m_wr, m_rd;
  logic [255:0] m_load;
  logic [319:0] m_en;
  logic [1:0] m_sel;
  logic [15:0] m_err;

  task automatic chk(input string nm, input logic [319:0] act, input logic [319:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_state[0] = 0; m_state[1] = 0; m_wr = 0; m_rd = 0;
    m_load = '0; m_en = '0; m_sel = '0; m_err = '0;
  endtask

  task automatic model_step(input logic v, input logic [31:0] a, input logic [31:0] d, input logic r);
    bit acc, md, lst;
    int tp, g;
    acc = v && (m_state[m_wr] != 2);
    if (r && m_state[m_rd] == 2) begin
      m_state[m_rd] = 0;
      m_rd = 1 - m_rd;
    end
    m_en = '0;
    if (acc) begin
      md = a[31];
      tp = int'(a[9:6]);
      g = int'(a[2:0]);
      lst = (a[3:0] == 4'hF) && (md || tp == 8);
      m_sel = {m_wr[0], a[3]};
      m_state[m_wr] = lst ? 2 : 1;
      if (lst) m_wr = 1 - m_wr;
      m_load = '0;
      m_load[g*32 +: 32] = d;
      for (int p = 0; p < 32; p++)
        if (p / 4 == g) m_en[p*10 +: 10] = md ? 10'h200 : (tp < 9 ? 10'(1 << tp) : 10'h0);
      if (ERR_ON && !md && tp >= 9 && m_err != 16'hFFFF) m_err = m_err + 16'd1;
    end
  endtask

  task automatic check_model();
    chk("mdl_ready", weight_ready, m_state[m_wr] != 2);
    chk("mdl_load", weight_load, m_load);
    chk("mdl_en", weight_load_en, m_en);
    chk("mdl_sel", weight_load_sel, m_sel);
    chk("mdl_full", bank_full, {m_state[1] == 2, m_state[0] == 2});
    chk("mdl_rd", rd_bank, m_rd[0]);
    chk("mdl_err", err_cnt, m_err);
  endtask

  task automatic cycle(input logic v, input logic [31:0] a, input logic [31:0] d, input logic r);
    weight_valid = v; weight_waddr = a; weight_wdata = d; bank_release = r;
    @(posedge clk);
    model_step(v, a, d, r);
    #1;
    check_model();
    weight_valid = 1'b0; bank_release = 1'b0;
  endtask

  task automatic do_reset();
    weight_valid = 1'b0; bank_release = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #2;
    chk("rst_ready", weight_ready, 1'b1);
    chk("rst_load", weight_load, '0);
    chk("rst_en", weight_load_en, '0);
    chk("rst_sel", weight_load_sel, 2'b00);
    chk("rst_full", bank_full, 2'b00);
    chk("rst_rd", rd_bank, 1'b0);
    chk("rst_err", err_cnt, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic v; logic r; logic [31:0] a; logic [31:0] d;
    logic [1:0] full; logic rdy; logic rd; logic [1:0] sel;
    int pe; logic [9:0] en; logic [31:0] lane; int err;
  } vec_t;
  vec_t tv [8];

  initial begin
    logic [319:0] ev;
    logic [31:0] a;
    tv[0] = '{1'b1, 1'b0, 32'h8000_000F, 32'hA5A5_A5A5, 2'b01, 1'b1, 1'b0, 2'b01, 28, 10'h200, 32'hA5A5_A5A5, 0};
    tv[1] = '{1'b1, 1'b0, 32'h0000_00C2, 32'h1111_2222, 2'b01, 1'b1, 1'b0, 2'b10, 8, 10'h008, 32'h1111_2222, 0};
    tv[2] = '{1'b0, 1'b1, 32'h0000_0000, 32'h0000_0000, 2'b00, 1'b1, 1'b1, 2'b10, 8, 10'h000, 32'h1111_2222, 0};
    tv[3] = '{1'b1, 1'b0, 32'h8000_000D, 32'hDEAD_BEEF, 2'b00, 1'b1, 1'b1, 2'b11, 20, 10'h200, 32'hDEAD_BEEF, 0};
    tv[4] = '{1'b1, 1'b0, 32'h0000_020F, 32'hCAFE_0001, 2'b10, 1'b1, 1'b1, 2'b11, 28, 10'h100, 32'hCAFE_0001, 0};
    tv[5] = '{1'b1, 1'b0, 32'h0000_0300, 32'h0000_0077, 2'b10, 1'b1, 1'b1, 2'b00, 0, 10'h000, 32'h0000_0077, 1};
    tv[6] = '{1'b1, 1'b0, 32'h0000_024F, 32'h0000_0099, 2'b10, 1'b1, 1'b1, 2'b01, 28, 10'h000, 32'h0000_0099, 2};
    tv[7] = '{1'b1, 1'b1, 32'h8000_000F, 32'h0000_0088, 2'b01, 1'b1, 1'b0, 2'b01, 28, 10'h200, 32'h0000_0088, 2};
    rst_n = 1'b1;
    #1;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      cycle(tv[i].v, tv[i].a, tv[i].d, tv[i].r);
      ev = '0;
      for (int q = 0; q < 4; q++) ev[((tv[i].pe / 4) * 4 + q) * 10 +: 10] = tv[i].en;
      chk("tbl_full", bank_full, tv[i].full);
      chk("tbl_ready", weight_ready, tv[i].rdy);
      chk("tbl_rd", rd_bank, tv[i].rd);
      chk("tbl_sel", weight_load_sel, tv[i].sel);
      chk("tbl_en", weight_load_en, ev);
      chk("tbl_lane", weight_load[(tv[i].pe / 4) * 32 +: 32], tv[i].lane);
      chk("tbl_err", err_cnt, ERR_ON ? 16'(tv[i].err) : 16'h0);
    end
    // full 3x3 fill of bank 0, then 1x1 fill of bank 1, then stall and release
    do_reset();
    for (int t = 0; t < 9; t++)
      for (int s = 0; s < 16; s++) begin
        cycle(1'b1, 32'((t << 6) | s), $urandom, 1'b0);
        chk("fill_full0", bank_full, (t == 8 && s == 15) ? 2'b01 : 2'b00);
      end
    for (int s = 0; s < 16; s++) cycle(1'b1, 32'h8000_0000 | 32'(s), $urandom, 1'b0);
    chk("both_full", bank_full, 2'b11);
    chk("both_ready", weight_ready, 1'b0);
    cycle(1'b1, 32'h8000_0003, 32'h1234_5678, 1'b0);
    chk("held_en", weight_load_en, '0);
    chk("held_ready", weight_ready, 1'b0);
    cycle(1'b0, 32'h0, 32'h0, 1'b1);
    chk("rel_full", bank_full, 2'b10);
    chk("rel_rd", rd_bank, 1'b1);
    chk("rel_ready", weight_ready, 1'b1);
    // release of bank 0 coinciding with the last beat of bank 1
    do_reset();
    cycle(1'b1, 32'h8000_000F, 32'h1, 1'b0);
    cycle(1'b1, 32'h8000_0000, 32'h2, 1'b0);
    cycle(1'b1, 32'h8000_000F, 32'h3, 1'b1);
    chk("same_full", bank_full, 2'b10);
    chk("same_rd", rd_bank, 1'b1);
    chk("same_ready", weight_ready, 1'b1);
    // reset in the middle of a fill
    do_reset();
    for (int i = 0; i < 50; i++) cycle(1'b1, 32'(((i / 16) << 6) | (i % 16)), $urandom, 1'b0);
    do_reset();
    cycle(1'b1, 32'h8000_000F, 32'h55, 1'b0);
    chk("post_rst_sel", weight_load_sel, 2'b01);
    chk("post_rst_full", bank_full, 2'b01);
    // illegal taps in 3x3 mode
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 32'h0000_0300 | 32'(i), 32'h99, 1'b0);
      chk("ill_en", weight_load_en, '0);
    end
    chk("ill_err", err_cnt, ERR_ON ? 16'd3 : 16'd0);
    // random traffic
    do_reset();
    for (int i = 0; i < 2500; i++) begin
      a = $urandom;
      if ($urandom_range(0, 3) == 0) a[3:0] = 4'hF;
      if ($urandom_range(0, 2) == 0) a[9:6] = 4'd8;
      cycle($urandom_range(0, 3) != 0, a, $urandom, $urandom_range(0, 5) == 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
